inst_sequencer: RTL and testbench

//  On-chip instruction generator for fullchip: drives inst[19:0] and mem_in so no external bench has to sequence them.
//  - Sequences Q/K load, K preload to the array, execute, ofifo->pmem move and SFP normalization.
//  - Sits between the host data stream and fullchip. Source of mem_in is a valid/ready stream.

---
 rtl/inst_sequencer_if.sv | 10 +
 rtl/inst_sequencer.sv | 147 ++++++++++++++
 tb/tb_inst_sequencer.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/inst_sequencer_if.sv
// inst_seq_if: host Q/K vector valid/ready stream feeding the instruction sequencer
interface inst_seq_if #(
  parameter int W = 64
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  modport master (output in_valid, in_data, input in_ready);
  modport slave  (input in_valid, in_data, output in_ready);
endinterface

// File: rtl/inst_sequencer.sv
// inst_sequencer: on-chip generator of fullchip inst[19:0] and mem_in for Q/K load, K preload,
// execute, ofifo->pmem move and SFP normalization; every output is registered.
module inst_sequencer #(
  parameter int bw          = 8,
  parameter int pr          = 8,
  parameter int col         = 8,
  parameter int total_cycle = 8,
  parameter int gap_cycles  = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  inst_seq_if.slave       host,
  output logic [pr*bw-1:0] mem_in,
  output logic [19:0]     inst,
  output logic            busy,
  output logic            done
);
  typedef enum logic [3:0] {IDLE, QWR, KWR, GAP1, KLD, WAIT1, EXE, WAIT2, MOV, NRM, FIN} state_t;
  typedef enum logic [1:0] {N_ACC, N_HOLD, N_DIV, N_WB} nrm_t;
  localparam logic [7:0] TC_LAST  = 8'(total_cycle - 1);
  localparam logic [7:0] TC_END   = 8'(total_cycle);
  localparam logic [7:0] COL_LAST = 8'(col - 1);
  localparam logic [7:0] COL_END  = 8'(col);
  localparam logic [7:0] KLD_END  = 8'(col + 2);
  localparam logic [7:0] GAP_LAST = 8'(gap_cycles - 1);
  state_t            state_q, state_d;
  nrm_t              ph_q, ph_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [19:0]       inst_q, inst_d;
  logic [pr*bw-1:0]  mem_in_q, mem_in_d;
  logic              in_ready_q, in_ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              fire;
  logic [3:0]        add;
  assign fire = host.in_valid & in_ready_q;
  assign add  = cnt_q[3:0];
  always_comb begin
    state_d  = state_q;
    ph_d     = ph_q;
    cnt_d    = cnt_q + 8'd1;
    inst_d   = '0;
    mem_in_d = mem_in_q;
    done_d   = 1'b0;
    busy_d   = busy_q;
    case (state_q)
      IDLE: begin
        state_d = start ? QWR : IDLE;
        busy_d  = start;
        cnt_d   = '0;
      end
      QWR: begin
        inst_d[4]     = fire;
        inst_d[15:12] = fire ? add : 4'd0;
        mem_in_d      = fire ? host.in_data : mem_in_q;
        cnt_d         = !fire ? cnt_q : (cnt_q == TC_LAST) ? 8'd0 : cnt_q + 8'd1;
        state_d       = (fire && cnt_q == TC_LAST) ? KWR : QWR;
      end
      KWR: begin
        inst_d[2]     = fire;
        inst_d[15:12] = fire ? add : 4'd0;
        mem_in_d      = fire ? host.in_data : mem_in_q;
        cnt_d         = !fire ? cnt_q : (cnt_q == COL_LAST) ? 8'd0 : cnt_q + 8'd1;
        state_d       = (fire && cnt_q == COL_LAST) ? GAP1 : KWR;
      end
      GAP1: begin
        state_d = (cnt_q == 8'd1) ? KLD : GAP1;
        cnt_d   = (cnt_q == 8'd1) ? 8'd0 : cnt_q + 8'd1;
      end
      KLD: begin
        // cycle 0 primes the array, 1..col stream K rows, col+1 flushes load, col+2 is idle
        inst_d[6]     = cnt_q != KLD_END;
        inst_d[3]     = cnt_q != 8'd0 && cnt_q <= COL_END;
        inst_d[15:12] = (cnt_q > 8'd1 && cnt_q <= COL_END) ? 4'(cnt_q - 8'd1) : 4'd0;
        state_d       = (cnt_q == KLD_END) ? WAIT1 : KLD;
        cnt_d         = (cnt_q == KLD_END) ? 8'd0 : cnt_q + 8'd1;
      end
      WAIT1: begin
        state_d = (cnt_q == GAP_LAST) ? EXE : WAIT1;
        cnt_d   = (cnt_q == GAP_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      EXE: begin
        inst_d[7]     = cnt_q != TC_END;
        inst_d[5]     = cnt_q != TC_END;
        inst_d[15:12] = (cnt_q != TC_END) ? add : 4'd0;
        state_d       = (cnt_q == TC_END) ? WAIT2 : EXE;
        cnt_d         = (cnt_q == TC_END) ? 8'd0 : cnt_q + 8'd1;
      end
      WAIT2: begin
        state_d = (cnt_q == GAP_LAST) ? MOV : WAIT2;
        cnt_d   = (cnt_q == GAP_LAST) ? 8'd0 : cnt_q + 8'd1;
      end
      MOV: begin
        inst_d[16]   = 1'b1;
        inst_d[0]    = 1'b1;
        inst_d[11:8] = add;
        state_d      = (cnt_q == TC_LAST) ? NRM : MOV;
        cnt_d        = (cnt_q == TC_LAST) ? 8'd0 : cnt_q + 8'd1;
        ph_d         = N_ACC;
      end
      NRM: begin
        inst_d[11:8] = add;
        inst_d[18]   = ph_q == N_ACC;
        inst_d[1]    = ph_q == N_ACC;
        inst_d[17]   = ph_q == N_DIV;
        inst_d[19]   = ph_q == N_WB;
        inst_d[0]    = ph_q == N_WB;
        ph_d         = nrm_t'(ph_q + 2'd1);
        cnt_d        = (ph_q == N_WB) ? cnt_q + 8'd1 : cnt_q;
        state_d      = (ph_q == N_WB && cnt_q == TC_LAST) ? FIN : NRM;
      end
      FIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    in_ready_d = state_d == QWR || state_d == KWR;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ph_q       <= N_ACC;
      cnt_q      <= '0;
      inst_q     <= '0;
      mem_in_q   <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      inst_q     <= inst_d;
      mem_in_q   <= mem_in_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end
  assign host.in_ready = in_ready_q;
  assign mem_in        = mem_in_q;
  assign inst          = inst_q;
  assign busy          = busy_q;
  assign done          = done_q;
endmodule

// File: tb/tb_inst_sequencer.sv
// tb_inst_sequencer: scoreboard bench; expected inst/mem_in words are queued with their
// absolute cycle and a monitor pops them whenever the DUT drives a nonzero inst or done.
module tb_inst_sequencer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [63:0] mem_in;
  logic [19:0] inst;
  logic        busy, done;
  inst_seq_if #(.W(64)) host();
  inst_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .host(host),
    .mem_in(mem_in), .inst(inst), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  int tick = 0;
  always @(posedge clk) tick <= tick + 1;
  typedef struct { int t; logic [19:0] inst; logic [63:0] mem; logic done; } exp_t;
  typedef struct { int t; logic [19:0] inst; logic [63:0] mem; } spot_t;
  exp_t  sb[$];
  spot_t spq[$];
  exp_t  e;
  spot_t sp;
  logic [63:0] vec [16];
  int tests = 0;
  int fails = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %h expected %h at tick %0d", nm, act, want, tick);
    end
  endtask
  task automatic push(input int t, input logic [19:0] w, input logic [63:0] m, input logic d);
    exp_t x;
    x.t = t; x.inst = w; x.mem = m; x.done = d;
    sb.push_back(x);
  endtask
  task automatic spot(input int t, input logic [19:0] w, input logic [63:0] m);
    spot_t x;
    x.t = t; x.inst = w; x.mem = m;
    spq.push_back(x);
  endtask
  task automatic push_run(input int t0, input int s_at, input int s_len);
    int D;
    logic [19:0] w;
    logic [19:0] nw [4];
    D = (s_at < 8) ? s_len : 0;
    nw[0] = 20'h40002; nw[1] = 20'h00000; nw[2] = 20'h20000; nw[3] = 20'h80001;
    for (int i = 0; i < 8; i++) push(t0 + 1 + i + ((i >= s_at) ? s_len : 0), 20'h00010 | (20'(i) << 12), vec[i], 1'b0);
    for (int j = 0; j < 8; j++) push(t0 + 9 + j + D, 20'h00004 | (20'(j) << 12), vec[8+j], 1'b0);
    for (int c = 0; c < 10; c++) begin
      w = 20'h00040;
      if (c >= 1 && c <= 8) w = w | 20'h00008;
      if (c >= 2 && c <= 8) w = w | (20'(c - 1) << 12);
      push(t0 + 19 + c + D, w, vec[15], 1'b0);
    end
    for (int i = 0; i < 8; i++) push(t0 + 40 + i + D, 20'h000A0 | (20'(i) << 12), vec[15], 1'b0);
    for (int i = 0; i < 8; i++) push(t0 + 59 + i + D, 20'h10001 | (20'(i) << 8), vec[15], 1'b0);
    for (int r = 0; r < 8; r++)
      for (int p = 0; p < 4; p++) begin
        w = nw[p] | (20'(r) << 8);
        if (w != 20'h0) push(t0 + 67 + 4*r + p + D, w, vec[15], 1'b0);
      end
    push(t0 + 99 + D, 20'h0, vec[15], 1'b1);
  endtask
  always @(negedge clk) if (!reset) begin
    while (spq.size() > 0 && spq[0].t <= tick) begin
      sp = spq.pop_front();
      if (sp.t == tick) begin
        chk("spot_inst", 64'(inst), 64'(sp.inst));
        chk("spot_mem_in", mem_in, sp.mem);
      end else chk("spot_missed_tick", 64'(tick), 64'(sp.t));
    end
    if (inst != 20'h0 || done) begin
      if (sb.size() == 0) chk("unexpected_output", {43'd0, done, inst}, 64'd0);
      else begin
        e = sb.pop_front();
        chk("sb_tick", 64'(tick), 64'(e.t));
        chk("sb_inst", 64'(inst), 64'(e.inst));
        chk("sb_mem_in", mem_in, e.mem);
        chk("sb_done", 64'(done), 64'(e.done));
      end
    end
  end
  task automatic run(input int s_at, input int s_len, input bit pulse, input int abort_k, input int exp_len);
    int t0, b, st, guard, D;
    bit fired;
    @(negedge clk);
    t0 = tick + 1;
    D = (s_at < 8) ? s_len : 0;
    push_run(t0, s_at, s_len);
    spot(t0 + 1, 20'h00010, vec[0]);
    spot(t0 + 16 + D, 20'h07004, vec[15]);
    spot(t0 + 43 + D, 20'h030A0, vec[15]);
    if (abort_k == 0) begin
      spot(t0 + 64 + D, 20'h10501, vec[15]);
      spot(t0 + 75 + D, 20'h40202, vec[15]);
      spot(t0 + 76 + D, 20'h00200, vec[15]);
      spot(t0 + 77 + D, 20'h20200, vec[15]);
      spot(t0 + 78 + D, 20'h80201, vec[15]);
    end
    start = 1'b1;
    host.in_valid = 1'b1;
    host.in_data = vec[0];
    b = 0; st = 0; guard = 0; fired = 1'b0;
    while (b < 16 && guard < 300) begin
      @(negedge clk);
      guard++;
      if (guard == 1) chk("busy_after_start", 64'(busy), 64'd1);
      start = 1'b0;
      if (fired) b++;
      if (b < 16) begin
        host.in_valid = !(b == s_at && st < s_len && host.in_ready);
        if (!host.in_valid) st++;
        host.in_data = vec[b];
      end
      fired = host.in_ready && host.in_valid && b < 16;
    end
    if (b < 16) chk("stream_timeout", 64'(b), 64'd16);
    if (abort_k > 0) begin
      while (tick < t0 + abort_k) @(negedge clk);
      #2 reset = 1'b1;
      #1 chk("inst_on_reset", 64'(inst), 64'd0);
      chk("busy_on_reset", 64'(busy), 64'd0);
      chk("in_ready_on_reset", 64'(host.in_ready), 64'd0);
      @(negedge clk);
      chk("inst_reset_edge", 64'(inst), 64'd0);
      reset = 1'b0;
      sb.delete();
      spq.delete();
      return;
    end
    while (!done && tick < t0 + exp_len + 20) begin
      @(negedge clk);
      start = pulse && tick == t0 + 79;
    end
    start = 1'b0;
    chk("done_seen", 64'(done), 64'd1);
    chk("run_length", 64'(tick - t0), 64'(exp_len));
    @(negedge clk);
    chk("busy_after_done", 64'(busy), 64'd0);
    chk("done_pulse_width", 64'(done), 64'd0);
    repeat (5) @(negedge clk);
    chk("stays_idle", 64'(busy), 64'd0);
    chk("sb_drained", 64'(sb.size()), 64'd0);
  endtask
  initial begin
    vec[0] = 64'h0102030405060708;
    for (int i = 1; i < 16; i++) vec[i] = 64'h0101010101010101 * 64'(i + 16);
    host.in_valid = 1'b0;
    host.in_data = '0;
    repeat (3) @(negedge clk);
    chk("reset_inst", 64'(inst), 64'd0);
    chk("reset_mem_in", mem_in, 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_in_ready", 64'(host.in_ready), 64'd0);
    reset = 1'b0;
    run(99, 0, 1'b0, 45, 99);
    run(99, 0, 1'b1, 0, 99);
    run(3, 3, 1'b0, 0, 102);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
